dual_mac_acc: RTL and testbench

Packed dual-lane signed multiply-accumulate with frame control. Two activations share one weight per beat, following the team's int8 MAC packing. Each beat forms the two products a1·w and a2·w and accumulates them over a frame into two independent accumulators. The frame end is marked by `inLast`. The block sits after the int8 multiplier stage and produces one dual dot-product result per frame for the downstream requantiser.

---
 rtl/dual_mac_acc_if.sv | 33 +++
 rtl/dual_mac_acc.sv | 151 +++++++++++++++
 tb/tb_dual_mac_acc.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_mac_acc_if.sv
// Handshake/data bundle for dual_mac_acc.
//   master : beat source; drives inDv, inA1, inA2, inW, inLast, inClr and
//            receives outDv, outAcc1, outAcc2, outOvf, outBeats.
//   slave  : the MAC block; the opposite directions.
// Widths follow DATA_W (activations), WEIGHT_W (shared weight) and
// ACC_W (accumulator / result).
interface dual_mac_acc_if #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32
);
  logic                       inDv;
  logic signed [DATA_W-1:0]   inA1;
  logic signed [DATA_W-1:0]   inA2;
  logic signed [WEIGHT_W-1:0] inW;
  logic                       inLast;
  logic                       inClr;
  logic                       outDv;
  logic signed [ACC_W-1:0]    outAcc1;
  logic signed [ACC_W-1:0]    outAcc2;
  logic [1:0]                 outOvf;
  logic [15:0]                outBeats;

  modport master (
    output inDv, inA1, inA2, inW, inLast, inClr,
    input  outDv, outAcc1, outAcc2, outOvf, outBeats
  );

  modport slave (
    input  inDv, inA1, inA2, inW, inLast, inClr,
    output outDv, outAcc1, outAcc2, outOvf, outBeats
  );
endinterface

// File: rtl/dual_mac_acc.sv
// Packed dual-lane signed multiply-accumulate with frame control.
// Each valid beat forms a1*w and a2*w and adds them into two independent
// accumulators; a beat flagged last closes the frame and emits one result.
// Ports:
//   clk   : rising-edge clock
//   rstN  : asynchronous active-low reset
//   bus   : dual_mac_acc_if slave modport
//           in : inDv, inA1, inA2, inW, inLast, inClr
//           out: outDv (1-cycle strobe), outAcc1, outAcc2, outOvf[1:0]
//                (sticky per-frame overflow, bit0 = lane 1), outBeats
// Pipeline: S0 input regs, S1 products, S2 accumulators, S3 output regs.
module dual_mac_acc #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32,
  parameter bit SAT_EN   = 1'b1
) (
  input logic           clk,
  input logic           rstN,
  dual_mac_acc_if.slave bus
);

  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Returns {overflow, sum}. Overflow is a same-sign add whose result sign
  // flips; with saturation the sum is pinned to the rail it ran into.
  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    logic                    ovf;
    s   = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    if (ovf && SAT_EN)
      s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    return {ovf, s};
  endfunction

  // ---- S0: input registers
  logic                       vld_p0, last_p0;
  logic signed [DATA_W-1:0]   a1_p0, a2_p0;
  logic signed [WEIGHT_W-1:0] w_p0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= bus.inDv & ~bus.inClr;
      last_p0 <= bus.inLast;
    end
  end

  always_ff @(posedge clk) begin
    a1_p0 <= bus.inA1;
    a2_p0 <= bus.inA2;
    w_p0  <= bus.inW;
  end

  // ---- S1: full-width products
  logic                     vld_p1, last_p1;
  logic signed [PROD_W-1:0] p1_p1, p2_p1;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= vld_p0 & ~bus.inClr;
      last_p1 <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    p1_p1 <= PROD_W'(a1_p0) * PROD_W'(w_p0);
    p2_p1 <= PROD_W'(a2_p0) * PROD_W'(w_p0);
  end

  // ---- S2: accumulators
  // first_p2 marks that the next valid beat opens a frame, so the stale
  // accumulator/flag/count contents are ignored instead of being cleared.
  logic                    done_p2, first_p2;
  logic signed [ACC_W-1:0] acc1_p2, acc2_p2;
  logic [1:0]              ovf_p2;
  logic [15:0]             beats_p2;

  logic signed [ACC_W-1:0] base1, base2, acc1_nxt, acc2_nxt;
  logic [ACC_W:0]          sum1, sum2;
  logic [1:0]              ovf_nxt;
  logic [15:0]             beats_base, beats_nxt;

  always_comb begin
    base1      = first_p2 ? '0 : acc1_p2;
    base2      = first_p2 ? '0 : acc2_p2;
    sum1       = acc_add(base1, ACC_W'(p1_p1));
    sum2       = acc_add(base2, ACC_W'(p2_p1));
    acc1_nxt   = sum1[ACC_W-1:0];
    acc2_nxt   = sum2[ACC_W-1:0];
    ovf_nxt    = (first_p2 ? 2'b00 : ovf_p2) | {sum2[ACC_W], sum1[ACC_W]};
    beats_base = first_p2 ? 16'd0 : beats_p2;
    beats_nxt  = (&beats_base) ? beats_base : beats_base + 16'd1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      done_p2  <= 1'b0;
      first_p2 <= 1'b1;
      acc1_p2  <= '0;
      acc2_p2  <= '0;
      ovf_p2   <= 2'b00;
      beats_p2 <= 16'd0;
    end else if (bus.inClr) begin
      done_p2  <= 1'b0;
      first_p2 <= 1'b1;
      acc1_p2  <= '0;
      acc2_p2  <= '0;
      ovf_p2   <= 2'b00;
      beats_p2 <= 16'd0;
    end else begin
      done_p2 <= vld_p1 & last_p1;
      if (vld_p1) begin
        acc1_p2  <= acc1_nxt;
        acc2_p2  <= acc2_nxt;
        ovf_p2   <= ovf_nxt;
        beats_p2 <= beats_nxt;
        first_p2 <= last_p1;
      end
    end
  end

  // ---- S3: output registers (abort does not reach this stage)
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.outDv    <= 1'b0;
      bus.outAcc1  <= '0;
      bus.outAcc2  <= '0;
      bus.outOvf   <= 2'b00;
      bus.outBeats <= 16'd0;
    end else begin
      bus.outDv <= done_p2;
      if (done_p2) begin
        bus.outAcc1  <= acc1_p2;
        bus.outAcc2  <= acc2_p2;
        bus.outOvf   <= ovf_p2;
        bus.outBeats <= beats_p2;
      end
    end
  end

endmodule

// File: tb/tb_dual_mac_acc.sv
// Bench for dual_mac_acc: three instances (ACC_W=32 saturating, ACC_W=17
// saturating, ACC_W=17 wrapping) share one stimulus stream. A queue-based
// frame model predicts every result; directed table rows and sequences add
// fixed expected values.
module tb_dual_mac_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstN = 1'b0;
  logic              dv = 1'b0, last = 1'b0, clr = 1'b0;
  logic signed [7:0] a1 = '0, a2 = '0, w = '0;

  dual_mac_acc_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(32)) b32 ();
  dual_mac_acc_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(17)) bs ();
  dual_mac_acc_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(17)) bw ();

  assign b32.inDv = dv;   assign bs.inDv = dv;   assign bw.inDv = dv;
  assign b32.inA1 = a1;   assign bs.inA1 = a1;   assign bw.inA1 = a1;
  assign b32.inA2 = a2;   assign bs.inA2 = a2;   assign bw.inA2 = a2;
  assign b32.inW = w;     assign bs.inW = w;     assign bw.inW = w;
  assign b32.inLast = last; assign bs.inLast = last; assign bw.inLast = last;
  assign b32.inClr = clr; assign bs.inClr = clr; assign bw.inClr = clr;

  dual_mac_acc #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(32), .SAT_EN(1'b1))
    u32 (.clk(clk), .rstN(rstN), .bus(b32));
  dual_mac_acc #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(17), .SAT_EN(1'b1))
    usat (.clk(clk), .rstN(rstN), .bus(bs));
  dual_mac_acc #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(17), .SAT_EN(1'b0))
    uwrap (.clk(clk), .rstN(rstN), .bus(bw));

  // Instance index: 0 = 32-bit sat, 1 = 17-bit sat, 2 = 17-bit wrap
  logic       dvo [3];
  longint     o1 [3], o2 [3];
  logic [1:0] ovo [3];
  int         bto [3];
  assign dvo[0] = b32.outDv; assign dvo[1] = bs.outDv; assign dvo[2] = bw.outDv;
  assign o1[0] = longint'(b32.outAcc1); assign o1[1] = longint'(bs.outAcc1);
  assign o1[2] = longint'(bw.outAcc1);
  assign o2[0] = longint'(b32.outAcc2); assign o2[1] = longint'(bs.outAcc2);
  assign o2[2] = longint'(bw.outAcc2);
  assign ovo[0] = b32.outOvf; assign ovo[1] = bs.outOvf; assign ovo[2] = bw.outOvf;
  assign bto[0] = int'(b32.outBeats); assign bto[1] = int'(bs.outBeats);
  assign bto[2] = int'(bw.outBeats);

  int tests = 0, fails = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { int cyc; int a1; int a2; int w; bit last; } beat_t;
  typedef struct packed { longint a1; longint a2; logic [1:0] ovf; int beats; int due; } res_t;

  int     accw [3] = '{32, 17, 17};
  bit     satm [3] = '{1'b1, 1'b1, 1'b0};
  beat_t  pend [$];
  res_t   expq [3][$];
  longint macc1 [3], macc2 [3];
  logic [1:0] movf [3];
  int     mbeats [3];

  // Add p into an accumulator of width aw; ov reports the result left range.
  function automatic longint lane_add(input longint acc, input longint p,
                                      input int aw, input bit s, output bit ov);
    longint hi, lo, r;
    hi = (longint'(1) << (aw - 1)) - 1;
    lo = -(longint'(1) << (aw - 1));
    r  = acc + p;
    ov = (r > hi) || (r < lo);
    if (ov) begin
      if (s) r = (r > hi) ? hi : lo;
      else   r = (r > hi) ? r - 2 * (hi + 1) : r + 2 * (hi + 1);
    end
    return r;
  endfunction

  task automatic frame_reset();
    for (int i = 0; i < 3; i++) begin
      macc1[i] = 0; macc2[i] = 0; movf[i] = 2'b00; mbeats[i] = 0;
    end
  endtask

  task automatic apply_beat(input beat_t b);
    bit   v1, v2;
    res_t r;
    for (int i = 0; i < 3; i++) begin
      macc1[i] = lane_add(macc1[i], longint'(b.a1 * b.w), accw[i], satm[i], v1);
      macc2[i] = lane_add(macc2[i], longint'(b.a2 * b.w), accw[i], satm[i], v2);
      movf[i]  = movf[i] | {v2, v1};
      mbeats[i] = (mbeats[i] < 65535) ? mbeats[i] + 1 : 65535;
      if (b.last) begin
        r.a1 = macc1[i]; r.a2 = macc2[i]; r.ovf = movf[i];
        r.beats = mbeats[i]; r.due = cyc + 1;
        expq[i].push_back(r);
        macc1[i] = 0; macc2[i] = 0; movf[i] = 2'b00; mbeats[i] = 0;
      end
    end
  endtask

  // A beat sampled at edge n takes effect two edges later and its result
  // is visible after the following edge; an abort drops every beat that has
  // not yet taken effect, including the one sampled with it.
  initial begin
    beat_t b;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstN) begin
        pend.delete();
        frame_reset();
      end else if (clr) begin
        pend.delete();
        frame_reset();
      end else begin
        if (dv) begin
          b = '{cyc, int'(a1), int'(a2), int'(w), last};
          pend.push_back(b);
        end
        while (pend.size() > 0 && pend[0].cyc + 2 <= cyc) begin
          b = pend.pop_front();
          apply_beat(b);
        end
      end
    end
  end

  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rstN) begin
          expq[i].delete();
        end else if (dvo[i]) begin
          if (expq[i].size() == 0 || expq[i][0].due != cyc) begin
            tests++; fails++;
            $display("FAIL model_unexpected_dv inst%0d: outDv=1 at cycle %0d, expected 0", i, cyc);
          end else begin
            e = expq[i].pop_front();
            chk($sformatf("model_acc1 inst%0d cyc%0d", i, cyc), o1[i], e.a1);
            chk($sformatf("model_acc2 inst%0d cyc%0d", i, cyc), o2[i], e.a2);
            chk($sformatf("model_ovf inst%0d cyc%0d", i, cyc), longint'(ovo[i]), longint'(e.ovf));
            chk($sformatf("model_beats inst%0d cyc%0d", i, cyc), longint'(bto[i]), longint'(e.beats));
          end
        end else if (expq[i].size() > 0 && expq[i][0].due <= cyc) begin
          e = expq[i].pop_front();
          tests++; fails++;
          $display("FAIL model_missing_dv inst%0d: outDv=0 at cycle %0d, expected 1", i, cyc);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int x1, input int x2, input int xw,
                       input bit l, input bit c);
    @(posedge clk);
    #2;
    dv = v; a1 = 8'(x1); a2 = 8'(x2); w = 8'(xw); last = l; clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic wait_dv(input int limit, output int k);
    k = -1;
    for (int j = 0; j < limit; j++) begin
      @(negedge clk);
      if (dvo[0]) begin
        k = j;
        break;
      end
    end
  endtask

  function automatic int pick();
    if ($urandom_range(0, 1) == 1) return ($urandom_range(0, 1) == 1) ? 127 : -128;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [5:0][7:0]  a1, a2, w;
    logic [3:0]       n, gap;
    logic [2:0][31:0] e1, e2;
    logic [2:0][1:0]  eo;
    logic [15:0]      eb;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int lat, k, rows;
    // basic 4-beat frame
    tbl[0].a1 = {8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1};
    tbl[0].a2 = {8'd0, 8'd0, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    tbl[0].w  = {6{8'd3}};
    tbl[0].n = 4'd4; tbl[0].gap = 4'd0;
    tbl[0].e1 = {3{32'sd30}}; tbl[0].e2 = {3{-32'sd30}};
    tbl[0].eo = '0; tbl[0].eb = 16'd4;
    // extremes with two bubbles after beat 1
    tbl[1].a1 = {6{8'h80}}; tbl[1].a2 = {6{8'h7F}}; tbl[1].w = {6{8'h80}};
    tbl[1].n = 4'd3; tbl[1].gap = 4'd2;
    tbl[1].e1 = {3{32'sd49152}}; tbl[1].e2 = {3{-32'sd48768}};
    tbl[1].eo = '0; tbl[1].eb = 16'd3;
    // 5 x 16129 passes 65535 on the 17-bit lanes, then one -127 beat
    tbl[2].a1 = {8'hFF, {5{8'd127}}}; tbl[2].a2 = '0; tbl[2].w = {6{8'd127}};
    tbl[2].n = 4'd6; tbl[2].gap = 4'd0;
    tbl[2].e1 = {-32'sd50554, 32'sd65408, 32'sd80518}; tbl[2].e2 = '0;
    tbl[2].eo = {2'b01, 2'b01, 2'b00}; tbl[2].eb = 16'd6;
    // clean frame after overflow
    tbl[3].a1 = {6{8'd2}}; tbl[3].a2 = {6{8'hFD}}; tbl[3].w = {6{8'hFB}};
    tbl[3].n = 4'd2; tbl[3].gap = 4'd0;
    tbl[3].e1 = {3{-32'sd20}}; tbl[3].e2 = {3{32'sd30}};
    tbl[3].eo = '0; tbl[3].eb = 16'd2;
    rows = 4;

    // reset held with random inputs
    repeat (4) drive($urandom_range(0, 1) == 1, pick(), pick(), pick(), 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_dv inst%0d", i), longint'(dvo[i]), 0);
      chk($sformatf("rst_acc1 inst%0d", i), o1[i], 0);
      chk($sformatf("rst_acc2 inst%0d", i), o2[i], 0);
      chk($sformatf("rst_ovf inst%0d", i), longint'(ovo[i]), 0);
      chk($sformatf("rst_beats inst%0d", i), longint'(bto[i]), 0);
    end
    @(posedge clk); #2;
    rstN = 1'b1; dv = 1'b0; last = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("idle_dv cycle%0d", j), longint'(dvo[0]), 0);
    end

    // table-driven frames
    for (int r = 0; r < rows; r++) begin
      for (int b = 0; b < int'(tbl[r].n); b++) begin
        drive(1'b1, $signed(tbl[r].a1[b]), $signed(tbl[r].a2[b]), $signed(tbl[r].w[b]),
              b == int'(tbl[r].n) - 1, 1'b0);
        if (b == 0) repeat (int'(tbl[r].gap)) drive(1'b0, pick(), pick(), pick(), 1'b1, 1'b0);
      end
      idle();
      wait_dv(8, lat);
      chk($sformatf("row%0d_latency", r), lat, 3);
      if (lat >= 0)
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("row%0d_acc1 inst%0d", r, i), o1[i], longint'($signed(tbl[r].e1[i])));
          chk($sformatf("row%0d_acc2 inst%0d", r, i), o2[i], longint'($signed(tbl[r].e2[i])));
          chk($sformatf("row%0d_ovf inst%0d", r, i), longint'(ovo[i]), longint'(tbl[r].eo[i]));
          chk($sformatf("row%0d_beats inst%0d", r, i), longint'(bto[i]), longint'(tbl[r].eb));
        end
      repeat (3) @(negedge clk);
    end

    // back-to-back single-beat frames
    drive(1'b1, 5, 0, 2, 1'b1, 1'b0);
    drive(1'b1, 6, 0, 2, 1'b1, 1'b0);
    drive(1'b1, 7, 0, 2, 1'b1, 1'b0);
    idle();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("b2b_dv step%0d", j), longint'(dvo[0]), (j >= 1 && j <= 3) ? 1 : 0);
      if (j >= 1 && j <= 3) begin
        chk($sformatf("b2b_acc1 step%0d", j), o1[0], 10 + 2 * (j - 1));
        chk($sformatf("b2b_beats step%0d", j), longint'(bto[0]), 1);
      end
    end

    // abort on beat 2, then a fresh 2-beat frame
    drive(1'b1, 9, 4, 1, 1'b0, 1'b0);
    drive(1'b1, 9, 4, 1, 1'b0, 1'b1);
    drive(1'b1, 1, 0, 1, 1'b0, 1'b0);
    drive(1'b1, 1, 0, 1, 1'b1, 1'b0);
    idle();
    wait_dv(10, k);
    chk("clr_result_seen", longint'(k >= 0), 1);
    if (k >= 0) begin
      chk("clr_acc1", o1[0], 2);
      chk("clr_acc2", o2[0], 0);
      chk("clr_beats", longint'(bto[0]), 2);
    end
    repeat (3) @(negedge clk);

    // reset in the middle of a frame
    drive(1'b1, 50, 50, 1, 1'b0, 1'b0);
    drive(1'b1, 50, 50, 1, 1'b0, 1'b0);
    @(posedge clk); #2;
    rstN = 1'b0; dv = 1'b0;
    @(posedge clk); #2;
    rstN = 1'b1;
    drive(1'b1, 3, -2, 3, 1'b1, 1'b0);
    idle();
    wait_dv(10, k);
    chk("midrst_result_seen", longint'(k >= 0), 1);
    if (k >= 0) begin
      chk("midrst_acc1", o1[0], 9);
      chk("midrst_acc2", o2[0], -6);
      chk("midrst_beats", longint'(bto[0]), 1);
    end

    // randomized traffic, checked by the model
    for (int j = 0; j < 800; j++)
      drive($urandom_range(0, 3) != 0, pick(), pick(), pick(),
            $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    idle();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("drain inst%0d", i), longint'(expq[i].size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000 ns, expected to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
